mux_2a1: RTL and testbench

Two-to-one byte interleaver: the transmit-side counterpart of the 1:2 demux that splits one valid-qualified byte stream into lanes 0 and 1. Buffers each input lane and merges them into one stream on `clk_2f` in strict lane-0/lane-1 alternation. A downstream demux that toggles its lane selector on every valid byte restores both lanes exactly. Sits between the two per-lane byte sources and the serial/link path feeding the demux.

---
 rtl/mux_pkg.sv | 5 +
 rtl/fifo_lane.sv | 38 +++
 rtl/mux_2a1.sv | 48 ++++
 tb/tb_mux_2a1.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared constants and lane enum for the 2:1 byte interleaver.
package mux_pkg;
   localparam int DEFAULT_DATA_WIDTH = 8;
   typedef enum logic {LANE0 = 1'b0, LANE1 = 1'b1} lane_e;
endpackage

// File: rtl/fifo_lane.sv
// fifo_lane: per-lane synchronous FIFO with combinational head and full/empty status.
module fifo_lane #(
   parameter int DATA_WIDTH = mux_pkg::DEFAULT_DATA_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                  clk_2f,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  empty
);
   localparam int AW = $clog2(DEPTH);
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count;
   logic do_wr, do_rd;
   assign full = count == (AW + 1)'(DEPTH);
   assign empty = count == '0;
   assign rd_data = mem[rd_ptr];
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;
   always_ff @(posedge clk_2f or negedge reset)
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW + 1)'(do_wr) - (AW + 1)'(do_rd);
      end
   // Storage needs no reset: stale entries are unreachable once pointers clear.
   always_ff @(posedge clk_2f)
      if (do_wr) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/mux_2a1.sv
// mux_2a1: merges two buffered byte lanes into one stream in strict lane-0/lane-1 alternation.
module mux_2a1 import mux_pkg::*; #(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                  clk_2f,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in_0,
   input  logic                  valid_in_0,
   output logic                  ready_0,
   input  logic [DATA_WIDTH-1:0] data_in_1,
   input  logic                  valid_in_1,
   output logic                  ready_1,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic                  lane_out
);
   logic full_0, full_1, empty_0, empty_1, pop_0, pop_1;
   logic [DATA_WIDTH-1:0] head_0, head_1;
   lane_e sel;
   assign ready_0 = !full_0;
   assign ready_1 = !full_1;
   // Only the lane in turn may pop; the other waits even when it has data.
   assign pop_0 = sel == LANE0 && !empty_0;
   assign pop_1 = sel == LANE1 && !empty_1;
   fifo_lane #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_lane_0 (
      .clk_2f(clk_2f), .reset(reset), .wr_en(valid_in_0), .wr_data(data_in_0),
      .rd_en(pop_0), .rd_data(head_0), .full(full_0), .empty(empty_0)
   );
   fifo_lane #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_lane_1 (
      .clk_2f(clk_2f), .reset(reset), .wr_en(valid_in_1), .wr_data(data_in_1),
      .rd_en(pop_1), .rd_data(head_1), .full(full_1), .empty(empty_1)
   );
   always_ff @(posedge clk_2f or negedge reset)
      if (!reset) begin
         sel <= LANE0;
         data_out <= '0;
         valid_out <= 1'b0;
         lane_out <= 1'b0;
      end else begin
         valid_out <= pop_0 || pop_1;
         if (pop_0 || pop_1) begin
            data_out <= sel == LANE1 ? head_1 : head_0;
            lane_out <= sel == LANE1;
            sel <= sel == LANE0 ? LANE1 : LANE0;
         end
      end
endmodule

// File: tb/tb_mux_2a1.sv
// tb_mux_2a1: directed bench with a queue-based interleaver model checked every cycle.
module tb_mux_2a1;
   localparam int DW = 8;
   localparam int DEPTH = 4;
   logic clk_2f = 0, reset = 0;
   logic [DW-1:0] data_in_0 = 0, data_in_1 = 0, data_out;
   logic valid_in_0 = 0, valid_in_1 = 0, ready_0, ready_1, valid_out, lane_out;
   int errors = 0, checks = 0;
   bit armed = 0;
   logic [DW-1:0] q0[$], q1[$], got[$];
   logic [DW-1:0] m_data = 0;
   bit m_valid = 0, m_lane = 0, m_sel = 0;

   mux_2a1 #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk_2f(clk_2f), .reset(reset),
      .data_in_0(data_in_0), .valid_in_0(valid_in_0), .ready_0(ready_0),
      .data_in_1(data_in_1), .valid_in_1(valid_in_1), .ready_1(ready_1),
      .data_out(data_out), .valid_out(valid_out), .lane_out(lane_out)
   );

   always #5 clk_2f = ~clk_2f;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: two byte queues, a turn bit; pop the lane in turn, then accept pushes.
   always @(posedge clk_2f or negedge reset) begin
      bit p0, p1;
      if (!reset) begin
         q0.delete(); q1.delete();
         m_data = 0; m_valid = 0; m_lane = 0; m_sel = 0;
      end else begin
         p0 = valid_in_0 && q0.size() < DEPTH;
         p1 = valid_in_1 && q1.size() < DEPTH;
         m_valid = 0;
         if (!m_sel && q0.size() > 0) begin
            m_data = q0.pop_front(); m_valid = 1; m_lane = 0; m_sel = 1;
         end else if (m_sel && q1.size() > 0) begin
            m_data = q1.pop_front(); m_valid = 1; m_lane = 1; m_sel = 0;
         end
         if (p0) q0.push_back(data_in_0);
         if (p1) q1.push_back(data_in_1);
      end
   end

   always @(negedge clk_2f) if (armed) begin
      chk("valid_out", 32'(valid_out), 32'(m_valid));
      chk("data_out", 32'(data_out), 32'(m_data));
      chk("lane_out", 32'(lane_out), 32'(m_lane));
      chk("ready_0", 32'(ready_0), 32'(q0.size() != DEPTH));
      chk("ready_1", 32'(ready_1), 32'(q1.size() != DEPTH));
      if (valid_out) got.push_back(data_out);
   end

   task automatic step(input bit v0, input logic [DW-1:0] d0, input bit v1, input logic [DW-1:0] d1);
      valid_in_0 = v0; data_in_0 = d0; valid_in_1 = v1; data_in_1 = d1;
      @(posedge clk_2f);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0);
   endtask

   task automatic do_reset();
      reset = 0;
      idle(2);
      reset = 1;
      got.delete();
   endtask

   task automatic chk_got(input string name, input logic [DW-1:0] exp[$]);
      chk({name, "_len"}, 32'(got.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         chk(name, 32'(got[i]), 32'(exp[i]));
   endtask

   initial begin
      bit v0, v1;
      int i0, i1;
      for (int i = 0; i < 3; i++) begin
         step(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom));
         armed = 1;
      end
      chk("rst_valid", 32'(valid_out), 0);
      chk("rst_data", 32'(data_out), 0);
      chk("rst_ready", 32'({ready_0, ready_1}), 32'b11);
      reset = 1;
      idle(1);
      got.delete();
      step(1, 8'hA0, 0, 0);
      chk("no_bypass", 32'(valid_out), 0);
      step(0, 0, 0, 0);
      chk("lat_data", 32'(data_out), 32'hA0);
      chk("lat_valid", 32'(valid_out), 1);
      chk("lat_lane", 32'(lane_out), 0);
      step(0, 0, 0, 0);
      chk("single_valid", 32'(valid_out), 0);

      do_reset();
      for (int i = 0; i < 4; i++) step(1, 8'(8'h10 + i), 1, 8'(8'h20 + i));
      idle(6);
      chk_got("interleave", '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23});

      do_reset();
      step(0, 0, 1, 8'h55);
      idle(3);
      chk("strict_stall", 32'(got.size()), 0);
      step(1, 8'h33, 0, 0);
      idle(4);
      chk_got("strict", '{8'h33, 8'h55});

      do_reset();
      for (int i = 0; i < 6; i++) step(1, 8'(8'h40 + i), 0, 0);
      chk("full_ready0", 32'(ready_0), 0);
      chk("full_ready1", 32'(ready_1), 1);
      chk_got("full_stall", '{8'h40});
      for (int i = 0; i < 4; i++) step(0, 0, 1, 8'(8'h50 + i));
      idle(8);
      chk_got("full_drain", '{8'h40, 8'h50, 8'h41, 8'h51, 8'h42, 8'h52, 8'h43, 8'h53, 8'h44});

      do_reset();
      i0 = 0; i1 = 0;
      for (int c = 0; c < 400 && (i0 < 3 * DEPTH || i1 < 3 * DEPTH); c++) begin
         v0 = i0 < 3 * DEPTH && $urandom_range(0, 2) != 0;
         v1 = i1 < 3 * DEPTH && $urandom_range(0, 2) != 0;
         v0 = v0 && ready_0;
         v1 = v1 && ready_1;
         step(v0, 8'(8'h60 + i0), v1, 8'(8'h80 + i1));
         if (v0) i0++;
         if (v1) i1++;
      end
      chk("wrap_done", 32'(i0 + i1), 32'(6 * DEPTH));
      idle(20);
      chk("wrap_len", 32'(got.size()), 32'(6 * DEPTH));
      for (int k = 0; k < 3 * DEPTH && 2 * k + 1 < got.size(); k++) begin
         chk("wrap_l0", 32'(got[2 * k]), 32'(8'h60 + k));
         chk("wrap_l1", 32'(got[2 * k + 1]), 32'(8'h80 + k));
      end

      do_reset();
      step(0, 0, 1, 8'h90);
      step(0, 0, 1, 8'h91);
      step(1, 8'h70, 1, 8'h92);
      step(1, 8'h71, 0, 0);
      #2 reset = 0;
      #1;
      chk("mid_rst_valid", 32'(valid_out), 0);
      chk("mid_rst_data", 32'(data_out), 0);
      chk("mid_rst_lane", 32'(lane_out), 0);
      chk("mid_rst_ready", 32'({ready_0, ready_1}), 32'b11);
      idle(2);
      got.delete();
      reset = 1;
      idle(6);
      chk("mid_rst_stale", 32'(got.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
